nonce_sequencer: RTL and testbench
==================================

Name: nonce_sequencer

Overview:
- Upstream sequencer for the hashing-module controller: walks a 32-bit nonce range and, per nonce, pulses begin_hash and waits for hash_done.
- Compares the finished 256-bit hash against the difficulty target, then either reports a golden nonce, advances to the next nonce, or reports range exhausted.
- Owns abort handling (quit_hash) and a per-hash watchdog.

Parameters:
NONCE_W, 32, nonce width in bits
HASH_W, 256, hash/target width in bits
TIMEOUT, 1024, max cycles spent in WAIT_HASH before the watchdog fires (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  begin a search; sampled only in IDLE
abort  input  1  stop search; sampled in every non-IDLE state
nonce_base  input  NONCE_W  first nonce of the range; latched on accepted start
target  input  HASH_W  difficulty target; latched on accepted start
hash_done  input  1  one-cycle pulse from hashing controller, hash valid
final_hash  input  HASH_W  hash result, valid in the hash_done cycle only
begin_hash  output  1  one-cycle pulse starting a hash of current nonce
quit_hash  output  1  one-cycle pulse cancelling the hash in flight
nonce  output  NONCE_W  nonce currently being hashed
busy  output  1  high in every state except IDLE
found  output  1  sticky: a hash < target was found
golden_nonce  output  NONCE_W  nonce that produced the winning hash
exhausted  output  1  sticky: nonce 0xFFFFFFFF hashed without success
timeout_err  output  1  sticky: watchdog fired at least once this search

Behaviour:
- Reset (async, n_rst=0): state IDLE; all outputs 0; nonce, golden_nonce, target and hash registers 0; watchdog counter 0.
- All outputs are Moore (decoded from state/registers), with no combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT_HASH, COMPARE, FOUND, EXHAUSTED, QUIT.
- IDLE:
  - start=1 latches nonce<=nonce_base and target<=target.
  - It also clears found, exhausted, timeout_err and golden_nonce, then moves to ISSUE.
- ISSUE: begin_hash=1 for exactly this cycle; watchdog<=0; next WAIT_HASH.
- WAIT_HASH:
  - Watchdog increments each cycle.
  - hash_done=1 captures final_hash into hash_reg and moves to COMPARE.
  - Watchdog reaching TIMEOUT-1 without hash_done sets timeout_err and moves to QUIT_RETRY behaviour: quit_hash=1 for one cycle, then ISSUE with the same nonce.
- COMPARE (one cycle), unsigned hash_reg vs target_reg:
  - hash_reg < target_reg (strictly): golden_nonce<=nonce, found<=1, next FOUND.
  - Otherwise, nonce == all-ones: exhausted<=1, next EXHAUSTED. Nonce is not wrapped.
  - Otherwise: nonce<=nonce+1, next ISSUE.
  - Equality (hash == target) is a miss.
- FOUND / EXHAUSTED: busy=1 for one cycle, then IDLE. found/exhausted remain asserted until the next accepted start.
- QUIT: quit_hash=1 for one cycle, then IDLE. Entered on abort from ISSUE, WAIT_HASH or COMPARE.
- Abort priority:
  - abort overrides hash_done, watchdog and compare result in the same cycle.
  - abort in IDLE, FOUND or EXHAUSTED is ignored. FOUND/EXHAUSTED still return to IDLE.
- start while busy is ignored. Simultaneous start+abort in IDLE: start accepted.
- Per-nonce overhead: ISSUE(1) + WAIT_HASH(N) + COMPARE(1) cycles. begin_hash pulses are never closer than 3 cycles apart.
- hash_done outside WAIT_HASH is ignored.
- Async reset mid-search returns to IDLE immediately with no quit_hash pulse. The hashing controller shares the same reset.
- nonce increment is NONCE_W-bit modular, but it is never reached at all-ones because EXHAUSTED takes precedence.

Decomposition:
- Shared package miner_pkg holds:
  - the seq_state_t enum (bit [2:0]);
  - NONCE_W and HASH_W defaults;
  - the TIMEOUT default.
- One sub-module, target_compare: a combinational HASH_W-bit unsigned less-than on hash_reg/target_reg, split into 64-bit slices so it can later be pipelined.
- The watchdog is an inline counter.

Test Plan:
- Happy path: reset, nonce_base=0x10, target=0x0001<<240. Respond to begin_hash with hash_done after 5 cycles, final_hash=0x0000_00FF...(below target) on the 3rd hash. Required: found=1, golden_nonce=0x12, exactly 3 begin_hash pulses, busy falls the cycle after FOUND.
- Equality boundary: final_hash == target on every hash, nonce_base=0xFFFFFFFE. Required: 2 hashes, exhausted=1, found=0, nonce stays 0xFFFFFFFF with no wrap.
- Abort in WAIT_HASH on the same cycle as hash_done with a winning hash. Required: one quit_hash pulse next cycle, found=0, state IDLE, busy=0 the cycle after.
- Watchdog with TIMEOUT=16: never return hash_done for the first issue. Required: quit_hash pulse after 16 WAIT cycles, timeout_err=1, then begin_hash re-issued with the same nonce. A normal hash_done then proceeds.
- Mid-search async reset: n_rst low for 1 cycle during WAIT_HASH. Required: all outputs 0 immediately, no quit_hash. A subsequent start with nonce_base=0 issues nonce 0.
- Sticky/ignore: start pulsed while busy is ignored, so nonce is unchanged. After FOUND, a new start clears found and golden_nonce before the first begin_hash.

Source files
------------

// File: rtl/miner_pkg.sv
// miner_pkg: shared defaults and sequencer state encoding for the nonce search path.
package miner_pkg;
    localparam int NONCE_W_DEF = 32;
    localparam int HASH_W_DEF = 256;
    localparam int TIMEOUT_DEF = 1024;
    localparam int SLICE_W = 64;
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_HASH, COMPARE, FOUND, EXHAUSTED, QUIT, QUIT_RETRY
    } seq_state_t;
endpackage

// File: rtl/nonce_sequencer_target_compare.sv
// target_compare: unsigned hash < target, built from 64-bit slices so each slice can be staged later.
module target_compare
    import miner_pkg::*;
#(
    parameter int HASH_W = HASH_W_DEF
) (
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              less
);
    localparam int N = HASH_W / SLICE_W;
    logic [N-1:0] lt, eq;
    for (genvar s = 0; s < N; s++) begin : g_slice
        assign lt[s] = hash[s*SLICE_W +: SLICE_W] < target[s*SLICE_W +: SLICE_W];
        assign eq[s] = hash[s*SLICE_W +: SLICE_W] == target[s*SLICE_W +: SLICE_W];
    end
    // Walk low to high: a higher slice decides unless it is equal.
    always_comb begin
        less = 1'b0;
        for (int i = 0; i < N; i++) less = lt[i] | (eq[i] & less);
    end
endmodule

// File: rtl/nonce_sequencer.sv
// nonce_sequencer: walks a nonce range, issues one hash per nonce and checks it against the target.
module nonce_sequencer
    import miner_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int HASH_W = HASH_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic [HASH_W-1:0]  target,
    input  logic               hash_done,
    input  logic [HASH_W-1:0]  final_hash,
    output logic               begin_hash,
    output logic               quit_hash,
    output logic [NONCE_W-1:0] nonce,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic               exhausted,
    output logic               timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT);
    seq_state_t state, state_nx;
    logic [HASH_W-1:0] target_reg, hash_reg;
    logic [WD_W-1:0] wd;
    logic less, wd_last;

    target_compare #(.HASH_W(HASH_W)) u_cmp (
        .hash(hash_reg),
        .target(target_reg),
        .less(less)
    );

    assign wd_last = wd == WD_W'(TIMEOUT - 1);
    assign begin_hash = state == ISSUE;
    assign quit_hash = state == QUIT || state == QUIT_RETRY;
    assign busy = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = start ? ISSUE : IDLE;
            ISSUE:      state_nx = abort ? QUIT : WAIT_HASH;
            WAIT_HASH:  state_nx = abort ? QUIT : hash_done ? COMPARE : wd_last ? QUIT_RETRY : WAIT_HASH;
            COMPARE:    state_nx = abort ? QUIT : less ? FOUND : &nonce ? EXHAUSTED : ISSUE;
            // The quit pulse has already gone out, so an abort here just stops the retry.
            QUIT_RETRY: state_nx = abort ? IDLE : ISSUE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            nonce <= '0;
            golden_nonce <= '0;
            target_reg <= '0;
            hash_reg <= '0;
            wd <= '0;
            found <= 1'b0;
            exhausted <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                nonce <= nonce_base;
                target_reg <= target;
                golden_nonce <= '0;
                found <= 1'b0;
                exhausted <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (state == ISSUE) wd <= '0;
            if (state == WAIT_HASH) wd <= wd + WD_W'(1);
            if (state_nx == COMPARE) hash_reg <= final_hash;
            if (state_nx == QUIT_RETRY) timeout_err <= 1'b1;
            if (state_nx == FOUND) begin
                golden_nonce <= nonce;
                found <= 1'b1;
            end
            if (state_nx == EXHAUSTED) exhausted <= 1'b1;
            if (state == COMPARE && state_nx == ISSUE) nonce <= nonce + NONCE_W'(1);
        end
    end
endmodule

// File: tb/tb_nonce_sequencer.sv
// tb_nonce_sequencer: directed stimulus with a queue-based scoreboard checked by an independent monitor.
module tb_nonce_sequencer;
    localparam logic [255:0] TGT = 256'h1 << 240;
    localparam logic [255:0] WIN = 256'hFF;
    localparam logic [255:0] MISS = 256'h1 << 241;
    localparam int K_BEGIN = 0;
    localparam int K_QUIT = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [31:0] nonce;
        logic        found;
        logic        exh;
        logic        to;
        logic [31:0] golden;
    } ev_t;

    logic clk = 1'b0;
    logic n_rst, start, abort, hash_done;
    logic [31:0] nonce_base;
    logic [255:0] target, final_hash;
    logic begin_hash, quit_hash, busy, found, exhausted, timeout_err;
    logic [31:0] nonce, golden_nonce;
    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];
    logic bp;

    nonce_sequencer #(.NONCE_W(32), .HASH_W(256), .TIMEOUT(16)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .nonce_base(nonce_base), .target(target), .hash_done(hash_done),
        .final_hash(final_hash), .begin_hash(begin_hash), .quit_hash(quit_hash),
        .nonce(nonce), .busy(busy), .found(found), .golden_nonce(golden_nonce),
        .exhausted(exhausted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] n, input logic f, input logic e,
                        input logic t, input logic [31:0] g);
        ev_t ev;
        ev.kind = k; ev.nonce = n; ev.found = f; ev.exh = e; ev.to = t; ev.golden = g;
        exp_q.push_back(ev);
    endtask

    task automatic expect_ev(input int k);
        ev_t ev;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind=%0d actual=present required=none", k);
        end else begin
            ev = exp_q.pop_front();
            check("event_kind", 256'(k), 256'(ev.kind));
            if (k == K_BEGIN) check("begin_nonce", 256'(nonce), 256'(ev.nonce));
            if (k == K_DONE)
                check("done_flags", 256'({found, exhausted, timeout_err, golden_nonce}),
                      256'({ev.found, ev.exh, ev.to, ev.golden}));
        end
    endtask

    initial begin
        bp = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) bp = 1'b0;
            else begin
                if (begin_hash) expect_ev(K_BEGIN);
                if (quit_hash) expect_ev(K_QUIT);
                if (bp && !busy) expect_ev(K_DONE);
                bp = busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [255:0] tgt);
        nonce_base = base;
        target = tgt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_begin();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (begin_hash) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("begin_wait", 256'(0), 256'(1));
    endtask

    task automatic respond(input logic [255:0] h);
        repeat (5) @(posedge clk);
        #1;
        hash_done = 1'b1;
        final_hash = h;
        tick();
        hash_done = 1'b0;
    endtask

    task automatic hash_once(input logic [255:0] h);
        wait_begin();
        respond(h);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_wait", 256'(0), 256'(1));
    endtask

    function automatic logic [255:0] outs();
        return 256'({begin_hash, quit_hash, busy, found, exhausted, timeout_err, nonce, golden_nonce});
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        logic ok;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; hash_done = 1'b0;
        nonce_base = '0; target = '0; final_hash = '0;
        #1;
        check("reset_outputs", outs(), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick();

        push(K_BEGIN, 32'h10, 0, 0, 0, 0);
        push(K_BEGIN, 32'h11, 0, 0, 0, 0);
        push(K_BEGIN, 32'h12, 0, 0, 0, 0);
        push(K_DONE, 0, 1, 0, 0, 32'h12);
        do_start(32'h10, TGT);
        hash_once(MISS);
        hash_once(MISS);
        hash_once(WIN);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (found) begin
                ok = 1'b1;
                break;
            end
        end
        check("found_seen", 256'(ok), 256'(1));
        check("busy_in_found", 256'(busy), 256'(1));
        @(negedge clk);
        check("busy_after_found", 256'(busy), 256'(0));
        tick();

        push(K_BEGIN, 32'hFFFF_FFFE, 0, 0, 0, 0);
        push(K_BEGIN, 32'hFFFF_FFFF, 0, 0, 0, 0);
        push(K_DONE, 0, 0, 1, 0, 0);
        do_start(32'hFFFF_FFFE, TGT);
        hash_once(TGT);
        hash_once(TGT);
        wait_idle();
        check("no_wrap_nonce", 256'(nonce), 256'(32'hFFFF_FFFF));
        check("equal_not_found", 256'(found), 256'(0));
        tick();

        push(K_BEGIN, 32'h100, 0, 0, 0, 0);
        push(K_QUIT, 0, 0, 0, 0, 0);
        push(K_DONE, 0, 0, 0, 0, 0);
        do_start(32'h100, TGT);
        wait_begin();
        repeat (5) @(posedge clk);
        #1;
        hash_done = 1'b1;
        final_hash = WIN;
        abort = 1'b1;
        tick();
        hash_done = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abort_quit", 256'({quit_hash, found}), 256'(2'b10));
        @(negedge clk);
        check("abort_idle", 256'(busy), 256'(0));
        tick();

        push(K_BEGIN, 32'h20, 0, 0, 0, 0);
        push(K_QUIT, 0, 0, 0, 0, 0);
        push(K_BEGIN, 32'h20, 0, 0, 0, 0);
        push(K_DONE, 0, 1, 0, 1, 32'h20);
        do_start(32'h20, TGT);
        wait_begin();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (quit_hash) break;
        end
        check("watchdog_cycles", 256'(n), 256'(17));
        check("timeout_err_set", 256'(timeout_err), 256'(1));
        hash_once(WIN);
        wait_idle();
        tick();

        push(K_BEGIN, 32'h40, 0, 0, 0, 0);
        do_start(32'h40, TGT);
        wait_begin();
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check("midsearch_reset", outs(), 256'(0));
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick();
        push(K_BEGIN, 32'h0, 0, 0, 0, 0);
        push(K_BEGIN, 32'h1, 0, 0, 0, 0);
        push(K_DONE, 0, 1, 0, 0, 32'h1);
        do_start(32'h0, TGT);
        hash_once(MISS);
        hash_once(WIN);
        wait_idle();
        tick();

        push(K_BEGIN, 32'h55, 0, 0, 0, 0);
        push(K_BEGIN, 32'h56, 0, 0, 0, 0);
        push(K_DONE, 0, 1, 0, 0, 32'h56);
        do_start(32'h55, TGT);
        wait_begin();
        check("cleared_on_start", 256'({found, golden_nonce}), 256'(0));
        tick();
        nonce_base = 32'h99;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_busy", 256'(nonce), 256'(32'h55));
        respond(MISS);
        hash_once(WIN);
        wait_idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
